// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: packed control layout used by the ID/EX register
// and its consumers.
package pipe_pkg;

  localparam int CTRL_W        = 8;
  localparam int CTRL_REGWRITE = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_MEMREAD  = 5;
  localparam int CTRL_MEMWRITE = 4;
  localparam int CTRL_ALUSRC   = 3;
  localparam int CTRL_ALUOP_HI = 2;
  localparam int CTRL_ALUOP_LO = 1;
  localparam int CTRL_REGDST   = 0;

  localparam logic [CTRL_W-1:0] CTRL_NOP = 8'h00;

endpackage

// File: rtl/sat_counter.sv
// W-bit saturating event counter with async reset, enable and hold.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         hold_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    // Stops at all-ones instead of wrapping back to zero.
    if (!hold_i && en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with hold, bubble/flush kill and optional statistics
// counters (enabled by defining ID_EX_STATS_EN).
module id_ex_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              Hold_i,
  input  logic              Bubble_i,
  input  logic              Flush_i,
  input  logic [CTRL_W-1:0] Ctrl_i,
  input  logic [DATA_W-1:0] RsData_i,
  input  logic [DATA_W-1:0] RtData_i,
  input  logic [DATA_W-1:0] Imm_i,
  input  logic [DATA_W-1:0] PC_i,
  input  logic [4:0]        RsAddr_i,
  input  logic [4:0]        RtAddr_i,
  input  logic [4:0]        RdAddr_i,
  output logic [CTRL_W-1:0] Ctrl_o,
  output logic [DATA_W-1:0] RsData_o,
  output logic [DATA_W-1:0] RtData_o,
  output logic [DATA_W-1:0] Imm_o,
  output logic [DATA_W-1:0] PC_o,
  output logic [4:0]        RsAddr_o,
  output logic [4:0]        RtAddr_o,
  output logic [4:0]        RdAddr_o,
  output logic              MemRead_o,
  output logic              Valid_o,
  output logic [CNT_W-1:0]  Bubble_Count_o,
  output logic [CNT_W-1:0]  Flush_Count_o
);

  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [DATA_W-1:0] rs_data_d, rs_data_q, rt_data_d, rt_data_q;
  logic [DATA_W-1:0] imm_d, imm_q, pc_d, pc_q;
  logic [4:0]        rs_addr_d, rs_addr_q, rt_addr_d, rt_addr_q, rd_addr_d, rd_addr_q;
  logic              valid_d, valid_q;
  logic              kill;

  assign kill = Bubble_i | Flush_i;

  always_comb begin
    ctrl_d    = ctrl_q;
    valid_d   = valid_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    pc_d      = pc_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    rd_addr_d = rd_addr_q;
    if (!Hold_i) begin
      // Payload always loads; a killed slot is neutralised by zero control alone.
      rs_data_d = RsData_i;
      rt_data_d = RtData_i;
      imm_d     = Imm_i;
      pc_d      = PC_i;
      rs_addr_d = RsAddr_i;
      rt_addr_d = RtAddr_i;
      rd_addr_d = RdAddr_i;
      if (kill) begin
        ctrl_d  = CTRL_NOP;
        valid_d = 1'b0;
      end else begin
        ctrl_d  = Ctrl_i;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q    <= CTRL_NOP;
      valid_q   <= 1'b0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rd_addr_q <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      pc_q      <= pc_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign Ctrl_o    = ctrl_q;
  assign Valid_o   = valid_q;
  assign RsData_o  = rs_data_q;
  assign RtData_o  = rt_data_q;
  assign Imm_o     = imm_q;
  assign PC_o      = pc_q;
  assign RsAddr_o  = rs_addr_q;
  assign RtAddr_o  = rt_addr_q;
  assign RdAddr_o  = rd_addr_q;
  // Clearing this bit on a bubble is what releases the hazard unit's stall.
  assign MemRead_o = ctrl_q[CTRL_MEMREAD];

`ifdef ID_EX_STATS_EN
  // A simultaneous bubble and flush is attributed to the bubble only.
  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (Bubble_i),
    .hold_i (Hold_i),
    .cnt_o  (Bubble_Count_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (Flush_i & ~Bubble_i),
    .hold_i (Hold_i),
    .cnt_o  (Flush_Count_o)
  );
`else
  assign Bubble_Count_o = '0;
  assign Flush_Count_o  = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Randomised self-checking bench for id_ex_stage_reg against a behavioural model.
module tb_id_ex_stage_reg;

  localparam int DW    = 32;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int VEC_W = 8 + 4 * DW + 15 + 2 + 2 * CW;
`ifdef ID_EX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk_i, rst_i, Hold_i, Bubble_i, Flush_i;
  logic [7:0]    Ctrl_i, Ctrl_o;
  logic [DW-1:0] RsData_i, RtData_i, Imm_i, PC_i;
  logic [DW-1:0] RsData_o, RtData_o, Imm_o, PC_o;
  logic [4:0]    RsAddr_i, RtAddr_i, RdAddr_i, RsAddr_o, RtAddr_o, RdAddr_o;
  logic          MemRead_o, Valid_o;
  logic [CW-1:0] Bubble_Count_o, Flush_Count_o;

  int tests_run = 0;
  int tests_failed = 0;

  // Behavioural model state
  logic [7:0]    m_ctrl;
  logic [DW-1:0] m_rs, m_rt, m_imm, m_pc;
  logic [4:0]    m_rsa, m_rta, m_rda;
  logic          m_valid;
  int            m_bcnt, m_fcnt;

  logic [VEC_W-1:0] exp_q[$];

  id_ex_stage_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .Hold_i(Hold_i), .Bubble_i(Bubble_i), .Flush_i(Flush_i),
    .Ctrl_i(Ctrl_i), .RsData_i(RsData_i), .RtData_i(RtData_i), .Imm_i(Imm_i), .PC_i(PC_i),
    .RsAddr_i(RsAddr_i), .RtAddr_i(RtAddr_i), .RdAddr_i(RdAddr_i),
    .Ctrl_o(Ctrl_o), .RsData_o(RsData_o), .RtData_o(RtData_o), .Imm_o(Imm_o), .PC_o(PC_o),
    .RsAddr_o(RsAddr_o), .RtAddr_o(RtAddr_o), .RdAddr_o(RdAddr_o),
    .MemRead_o(MemRead_o), .Valid_o(Valid_o),
    .Bubble_Count_o(Bubble_Count_o), .Flush_Count_o(Flush_Count_o)
  );

  // Clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [VEC_W-1:0] dut_vec();
    return {Ctrl_o, RsData_o, RtData_o, Imm_o, PC_o, RsAddr_o, RtAddr_o, RdAddr_o,
            MemRead_o, Valid_o, Bubble_Count_o, Flush_Count_o};
  endfunction

  function automatic logic [VEC_W-1:0] exp_vec();
    logic [CW-1:0] b, f;
    b = STATS ? CW'(m_bcnt) : '0;
    f = STATS ? CW'(m_fcnt) : '0;
    return {m_ctrl, m_rs, m_rt, m_imm, m_pc, m_rsa, m_rta, m_rda,
            m_ctrl[5], m_valid, b, f};
  endfunction

  task automatic model_reset();
    m_ctrl = 8'h00; m_rs = '0; m_rt = '0; m_imm = '0; m_pc = '0;
    m_rsa = '0; m_rta = '0; m_rda = '0; m_valid = 1'b0; m_bcnt = 0; m_fcnt = 0;
  endtask

  // One clock edge as described by the block's rules: hold > kill > load.
  task automatic model_edge();
    if (Hold_i) return;
    m_rs = RsData_i; m_rt = RtData_i; m_imm = Imm_i; m_pc = PC_i;
    m_rsa = RsAddr_i; m_rta = RtAddr_i; m_rda = RdAddr_i;
    if (Bubble_i || Flush_i) begin
      m_ctrl = 8'h00;
      m_valid = 1'b0;
      if (Bubble_i) m_bcnt = (m_bcnt < CMAX) ? m_bcnt + 1 : CMAX;
      else          m_fcnt = (m_fcnt < CMAX) ? m_fcnt + 1 : CMAX;
    end else begin
      m_ctrl = Ctrl_i;
      m_valid = 1'b1;
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  task automatic drive_random(input int p_hold, input int p_bub, input int p_fl);
    Hold_i   = ($urandom_range(99) < p_hold);
    Bubble_i = ($urandom_range(99) < p_bub);
    Flush_i  = ($urandom_range(99) < p_fl);
    Ctrl_i   = 8'($urandom);
    RsData_i = $urandom; RtData_i = $urandom; Imm_i = $urandom; PC_i = $urandom;
    RsAddr_i = 5'($urandom); RtAddr_i = 5'($urandom); RdAddr_i = 5'($urandom);
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    drive_random(0, 0, 0);
    #3 rst_i = 1'b1;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    repeat (3) begin
      drive_random(0, 20, 20);
      tick();
    end
    // Assert reset between edges: outputs must clear without a clock edge.
    #3 rst_i = 1'b1;
    drive_random(30, 30, 30);
    model_reset();
    #1;
    tests_run++;
    if (dut_vec() !== '0) begin
      tests_failed++;
      $display("FAIL reset_async: got %h expected 0", dut_vec());
    end
    #2 rst_i = 1'b0;
    drive_random(0, 0, 0);
    Ctrl_i = 8'hA4; RtAddr_i = 5'd9;
    tick();
    tests_run++;
    if ({Ctrl_o, MemRead_o, RtAddr_o, Valid_o} !== {8'hA4, 1'b1, 5'd9, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_release: got ctrl=%h mr=%b rt=%0d v=%b expected ctrl=a4 mr=1 rt=9 v=1",
               Ctrl_o, MemRead_o, RtAddr_o, Valid_o);
    end
    tests_run++;
    if (dut_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL reset_release_all: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_load_use();
    int b0;
    b0 = m_bcnt;
    drive_random(0, 0, 0);
    Ctrl_i = 8'hE0; RtAddr_i = 5'd5;
    tick();
    tests_run++;
    if ({Ctrl_o, MemRead_o, RtAddr_o} !== {8'hE0, 1'b1, 5'd5}) begin
      tests_failed++;
      $display("FAIL load_use_lw: got ctrl=%h mr=%b rt=%0d expected ctrl=e0 mr=1 rt=5",
               Ctrl_o, MemRead_o, RtAddr_o);
    end
    drive_random(0, 0, 0);
    Bubble_i = 1'b1;
    tick();
    tests_run++;
    if ({Ctrl_o, Valid_o, MemRead_o} !== 10'b0) begin
      tests_failed++;
      $display("FAIL load_use_bubble: got ctrl=%h v=%b mr=%b expected all 0", Ctrl_o, Valid_o, MemRead_o);
    end
    tests_run++;
    if (Bubble_Count_o !== (STATS ? CW'(b0 + 1) : CW'(0))) begin
      tests_failed++;
      $display("FAIL load_use_count: got %0d expected %0d", Bubble_Count_o, STATS ? b0 + 1 : 0);
    end
    drive_random(0, 0, 0);
    tick();
    tests_run++;
    if (dut_vec() !== exp_vec() || Valid_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_use_resume: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_hold();
    logic [VEC_W-1:0] snap;
    drive_random(0, 0, 0);
    tick();
    snap = exp_vec();
    for (int i = 0; i < 3; i++) begin
      drive_random(100, 50, 50);
      tick();
      tests_run++;
      if (dut_vec() !== snap) begin
        tests_failed++;
        $display("FAIL hold_cycle%0d: got %h expected %h", i, dut_vec(), snap);
      end
    end
    drive_random(0, 0, 0);
    tick();
    tests_run++;
    if (Ctrl_o !== Ctrl_i || RsData_o !== RsData_i || PC_o !== PC_i || Valid_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_release: got ctrl=%h rs=%h pc=%h expected ctrl=%h rs=%h pc=%h",
               Ctrl_o, RsData_o, PC_o, Ctrl_i, RsData_i, PC_i);
    end
  endtask

  task automatic test_bubble_flush();
    int b0, f0;
    b0 = m_bcnt; f0 = m_fcnt;
    drive_random(0, 100, 100);
    tick();
    tests_run++;
    if (Ctrl_o !== 8'h00 || Bubble_Count_o !== (STATS ? CW'(b0 + 1) : CW'(0)) ||
        Flush_Count_o !== (STATS ? CW'(f0) : CW'(0))) begin
      tests_failed++;
      $display("FAIL both_kill: got ctrl=%h bc=%0d fc=%0d expected ctrl=0 bc=%0d fc=%0d",
               Ctrl_o, Bubble_Count_o, Flush_Count_o, STATS ? b0 + 1 : 0, STATS ? f0 : 0);
    end
    drive_random(0, 0, 100);
    tick();
    tests_run++;
    if (Ctrl_o !== 8'h00 || Valid_o !== 1'b0 || Flush_Count_o !== (STATS ? CW'(f0 + 1) : CW'(0)) ||
        Bubble_Count_o !== (STATS ? CW'(b0 + 1) : CW'(0))) begin
      tests_failed++;
      $display("FAIL flush_only: got ctrl=%h v=%b bc=%0d fc=%0d expected fc=%0d",
               Ctrl_o, Valid_o, Bubble_Count_o, Flush_Count_o, STATS ? f0 + 1 : 0);
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 300; i++) begin
      drive_random(20, 25, 25);
      tick();
      exp_q.push_back(exp_vec());
      tests_run++;
      if (dut_vec() !== exp_q[0]) begin
        tests_failed++;
        if (errs < 5) $display("FAIL random_cycle%0d: got %h expected %h", i, dut_vec(), exp_q[0]);
        errs++;
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_saturation();
    #3 rst_i = 1'b1;
    model_reset();
    #2 rst_i = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      drive_random(0, 100, 50);
      tick();
      if (i == 14 || i == 20) begin
        tests_run++;
        if (Bubble_Count_o !== (STATS ? CW'((i < CMAX) ? i : CMAX) : CW'(0)) ||
            Flush_Count_o !== '0) begin
          tests_failed++;
          $display("FAIL saturation_%0d: got bc=%0d fc=%0d expected bc=%0d fc=0",
                   i, Bubble_Count_o, Flush_Count_o, STATS ? ((i < CMAX) ? i : CMAX) : 0);
        end
      end
    end
    tests_run++;
    if (dut_vec() !== exp_vec()) begin
      tests_failed++;
      $display("FAIL saturation_all: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_hold();
    test_bubble_flush();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

ID/EX pipeline register of the 5-stage MIPS core: it captures decoded control, operand data and register addresses at the end of ID and presents them to EX one cycle later. It is the direct consumer of the hazard detection unit's bubble request. On a load-use hazard it inserts a bubble by clearing control while ID re-issues. It also feeds `MemRead_o` and `RtAddr_o` back to the hazard detection unit, and supports whole-pipe freeze (memory stall) and branch flush.

## Interface
Parameters:
- `DATA_W`, default 32: operand, immediate and PC width.
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk_i` input 1: core clock; all state updates on the rising edge.
- `rst_i` input 1: asynchronous, active-high reset.
- `Hold_i` input 1: freeze; all state keeps its value (memory/cache stall).
- `Bubble_i` input 1: load-use bubble request, driven by the hazard unit's `Stall_o`.
- `Flush_i` input 1: branch/jump flush of the instruction in ID.
- `Ctrl_i` input 8: packed control, `{RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, ALUOp[1:0], RegDst}`.
- `RsData_i`, `RtData_i`, `Imm_i`, `PC_i` input DATA_W each: ID operands, sign-extended immediate, PC+4.
- `RsAddr_i`, `RtAddr_i`, `RdAddr_i` input 5 each: register specifiers.
- `Ctrl_o` output 8: registered control, same packing as `Ctrl_i`.
- `RsData_o`, `RtData_o`, `Imm_o`, `PC_o` output DATA_W each: registered copies.
- `RsAddr_o`, `RtAddr_o`, `RdAddr_o` output 5 each: registered copies; `RtAddr_o` goes to the hazard unit's `ID_EX_RtAddr_i`.
- `MemRead_o` output 1: equals `Ctrl_o[MemRead]`; goes to the hazard unit's `ID_EX_MemRead_i`.
- `Valid_o` output 1: EX holds a real instruction (not a bubble or flush).
- `Bubble_Count_o`, `Flush_Count_o` output CNT_W each: statistics counters.

## Operation
- Update priority per rising edge:
  1. Reset.
  2. Hold.
  3. Bubble or Flush: kill.
  4. Normal load.
- Normal load (`Hold_i`=0, `Bubble_i`=0, `Flush_i`=0): every field loads its `_i` value; `Valid_o` becomes 1.
- Kill (`Hold_i`=0 and (`Bubble_i` or `Flush_i`)):
  - `Ctrl_o` becomes 8'h00 and `Valid_o` becomes 0.
  - Data, address and PC fields still load their inputs; downstream ignores them because control is zero.
- Hold (`Hold_i`=1): every register, including the counters, keeps its value. `Bubble_i` and `Flush_i` are ignored that cycle.
- `MemRead_o` is a wire from the registered control bit, so a bubble clears it and the hazard stall releases automatically after one cycle.
- Counters:
  - `Bubble_Count_o` increments on each kill cycle with `Bubble_i`=1.
  - `Flush_Count_o` increments on each kill cycle with `Flush_i`=1 and `Bubble_i`=0; a simultaneous Bubble and Flush counts as a bubble only.
  - Both saturate at all-ones and do not wrap.

## Timing
- Latency: inputs sampled at edge N appear on the outputs after edge N, with no combinational input-to-output path.
- Reset values: every output is 0, including `Valid_o`, `MemRead_o` and both counters.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge. Release takes effect at the first rising edge with `rst_i`=0.
- A single-cycle `Bubble_i` produces exactly one invalid EX slot. A `Bubble_i` held for k cycles produces k invalid slots.
- A counter at all-ones that sees another event stays at all-ones.

## Configuration
- `ID_EX_STATS_EN` defined: both counters are implemented as specified.
- `ID_EX_STATS_EN` undefined: the counters are not instantiated, and `Bubble_Count_o` and `Flush_Count_o` are tied to 0. The ports remain, so the port list is identical in both builds.
- Pipeline behaviour is identical either way.

## Structure
- Shared package `pipe_pkg` holds:
  - control bit-index constants `CTRL_REGWRITE`=7, `CTRL_MEMTOREG`=6, `CTRL_MEMREAD`=5, `CTRL_MEMWRITE`=4, `CTRL_ALUSRC`=3, `CTRL_ALUOP_HI`=2, `CTRL_ALUOP_LO`=1, `CTRL_REGDST`=0;
  - `CTRL_W`=8 and `CTRL_NOP`=8'h00.
- One sub-module, `sat_counter`: a CNT_W-bit saturating counter with async reset, enable and hold. It is instantiated twice inside the `ID_EX_STATS_EN` guard.

## Test plan
- Reset: assert `rst_i` between clock edges with random inputs -> all outputs 0 immediately; after release and one edge with `Ctrl_i`=8'hA4 and `RtAddr_i`=9 -> `Ctrl_o`=8'hA4, `MemRead_o`=1, `RtAddr_o`=9, `Valid_o`=1.
- Load-use: load `Ctrl_i`=8'hE0 (lw) with `RtAddr_i`=5, then one cycle of `Bubble_i`=1 -> that EX slot has `Ctrl_o`=0, `Valid_o`=0, `MemRead_o`=0 and `Bubble_Count_o`=1; the next edge with `Bubble_i`=0 loads normally.
- Hold: with `Hold_i`=1 for 3 cycles while `Ctrl_i`, data and `Bubble_i` toggle -> all outputs and counters unchanged; the first edge after `Hold_i` drops loads the current inputs.
- Simultaneous Bubble and Flush for one cycle -> `Ctrl_o`=0, `Bubble_Count_o` +1, `Flush_Count_o` unchanged; Flush alone for one cycle -> `Flush_Count_o` +1.
- Saturation (`CNT_W`=4): 20 consecutive bubble cycles -> `Bubble_Count_o` stops at 15; build with `ID_EX_STATS_EN` undefined -> both counters read 0 throughout.
